// File: rtl/nbb_mmio_pkg.sv
// nbb_mmio_pkg: register map offsets, CTRL/STATUS bit positions,
// default parameter values and the timer state type for nbb_mmio.
package nbb_mmio_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h01;
    localparam logic [7:0] OFF_LOAD   = 8'h02;
    localparam logic [7:0] OFF_COUNT  = 8'h03;
    localparam logic [7:0] OFF_DUTY   = 8'h04;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int STATUS_EXP_BIT = 0;

    localparam int          DEF_DATA_WIDTH = 16;
    localparam int          DEF_ADDR_WIDTH = 16;
    localparam logic [15:0] DEF_BASE_ADDR  = 16'hFF00;
    localparam int          DEF_NUM_LEDS   = 1;
    localparam int          DEF_PWM_WIDTH  = 8;
    localparam logic [31:0] DEF_CLOCK_DIV  = 32'h0000FFFF;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/nbb_pwm_channel.sv
// nbb_pwm_channel: one PWM colour channel with shadow/active duty.
// Ports: clock, reset (sync, active-low), write_en/write_duty load the
// shadow duty, wrap (counter at max) promotes shadow to active, count is
// the shared PWM counter, duty is the shadow readback, led_n the
// registered active-low output.
module nbb_pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [PWM_WIDTH-1:0] write_duty,
    input  logic                 wrap,
    input  logic [PWM_WIDTH-1:0] count,
    output logic [PWM_WIDTH-1:0] duty,
    output logic                 led_n
);

    logic [PWM_WIDTH-1:0] shadow;
    logic [PWM_WIDTH-1:0] active;

    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow <= '0;
            active <= '0;
            led_n  <= 1'b1;
        end else begin
            if (write_en)
                shadow <= write_duty;
            // New duty only lands at the period boundary so a period
            // is never cut short or stretched.
            if (wrap)
                active <= shadow;
            led_n <= !(count < active);
        end
    end

    assign duty = shadow;

endmodule

// File: rtl/nbb_mmio.sv
// nbb_mmio: memory-mapped countdown timer plus RGB LED PWM block.
// Ports: clock, reset (sync, active-low), read_enable, write_enable,
// address, write_data in; read_data/read_valid (1-clock latency),
// hit (combinational window decode), irq (timer expired), RGB
// (active-low, LED i = {B,G,R} at [3i+2:3i]) out.
// Build option: define NBB_MMIO_TIMER_EN to include the timer.
module nbb_mmio
    import nbb_mmio_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR),
    parameter int                    NUM_LEDS   = DEF_NUM_LEDS,
    parameter int                    PWM_WIDTH  = DEF_PWM_WIDTH,
    parameter logic [31:0]           CLOCK_DIV  = DEF_CLOCK_DIV
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read_enable,
    input  logic                    write_enable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    hit,
    output logic                    irq,
    output logic [3*NUM_LEDS-1:0]   RGB
);

    localparam int NUM_CH = 3 * NUM_LEDS;

    logic [7:0]            offset;
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_ok;

    assign hit       = address[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8];
    assign offset    = address[7:0];
    assign wr        = write_enable & hit;
    assign rd        = read_enable & hit;
    assign unused_ok = &{1'b0, write_data};

    // Free-running PWM counter shared by all channels.
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 pwm_wrap;

    assign pwm_wrap = &pwm_cnt;

    always_ff @(posedge clock) begin
        if (!reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    logic [PWM_WIDTH-1:0] duty [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic duty_we;

        assign duty_we = wr && (offset == 8'(int'(OFF_DUTY) + k));

        nbb_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .write_en   (duty_we),
            .write_duty (write_data[PWM_WIDTH-1:0]),
            .wrap       (pwm_wrap),
            .count      (pwm_cnt),
            .duty       (duty[k]),
            .led_n      (RGB[k])
        );
    end

`ifdef NBB_MMIO_TIMER_EN
    timer_state_t          state;
    logic                  auto_rl;
    logic                  exp;
    logic [DATA_WIDTH-1:0] load;
    logic [DATA_WIDTH-1:0] count;
    logic [31:0]           presc;
    logic                  tick;
    logic                  exp_set;
    logic                  exp_clr;

    assign tick    = presc == CLOCK_DIV;
    assign exp_set = (state == T_RUN) && tick && (count == '0);
    assign exp_clr = wr && (offset == OFF_STATUS)
                  && write_data[STATUS_EXP_BIT];

    always_ff @(posedge clock) begin
        if (!reset)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= T_IDLE;
            auto_rl <= 1'b0;
            exp     <= 1'b0;
            load    <= '0;
            count   <= '0;
        end else begin
            // A set in the same clock as a W1C wins.
            exp <= exp_set | (exp & ~exp_clr);
            if (state == T_RUN && tick) begin
                if (count != '0)
                    count <= count - 1'b1;
                else if (auto_rl)
                    count <= load;
                else
                    state <= T_IDLE;
            end
            // Software writes take priority over the timer's own update.
            if (wr && offset == OFF_CTRL) begin
                state   <= write_data[CTRL_EN_BIT] ? T_RUN : T_IDLE;
                auto_rl <= write_data[CTRL_AUTO_BIT];
            end
            if (wr && offset == OFF_LOAD) begin
                load  <= write_data;
                count <= write_data;
            end
        end
    end

    assign irq = exp;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (offset == 8'(int'(OFF_DUTY) + k))
                rd_mux = DATA_WIDTH'(duty[k]);
`ifdef NBB_MMIO_TIMER_EN
        if (offset == OFF_CTRL) begin
            rd_mux[CTRL_EN_BIT]   = state == T_RUN;
            rd_mux[CTRL_AUTO_BIT] = auto_rl;
        end
        if (offset == OFF_STATUS)
            rd_mux[STATUS_EXP_BIT] = exp;
        if (offset == OFF_LOAD)
            rd_mux = load;
        if (offset == OFF_COUNT)
            rd_mux = count;
`endif
    end

    // Registers are sampled before this edge's write lands, so a
    // coincident read returns the old value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd;
            read_data  <= rd ? rd_mux : '0;
        end
    end

endmodule
